// File: rtl/window_generator_pkg.sv
// Shared definitions for the window generator slice: default geometry,
// the default window type and a width helper for counters.
package window_generator_pkg;

    localparam int DEFAULT_SIGNAL_WIDTH     = 12;
    localparam int DEFAULT_KERNEL_DIMENSION = 3;
    localparam int DEFAULT_IMAGE_WIDTH      = 640;
    localparam int DEFAULT_IMAGE_HEIGHT     = 480;

    // Window at default geometry: [row][col][bit], row 0 / col 0 are the oldest.
    typedef logic [0:DEFAULT_KERNEL_DIMENSION-1][0:DEFAULT_KERNEL_DIMENSION-1]
                  [DEFAULT_SIGNAL_WIDTH-1:0] window_t;

    // Bits needed to index 0..n-1, never less than one bit.
    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_generator_line_buffer.sv
// One row of delay: a circular buffer of C_DEPTH pixels. Each accepted
// pixel is written and, on the same accept, the pixel that the *next*
// accept will need is prefetched, so dout_o always shows the pixel that
// was written exactly C_DEPTH accepts before the one currently presented.
module window_generator_line_buffer
    import window_generator_pkg::*;
#(
    parameter int C_SIGNAL_WIDTH = DEFAULT_SIGNAL_WIDTH,
    parameter int C_DEPTH        = DEFAULT_IMAGE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      accept_i,
    input  logic [C_SIGNAL_WIDTH-1:0] din_i,
    output logic [C_SIGNAL_WIDTH-1:0] dout_o
);

    localparam int AW = index_width(C_DEPTH);

    logic [C_SIGNAL_WIDTH-1:0] mem [C_DEPTH];
    logic [C_SIGNAL_WIDTH-1:0] dout_q;
    logic [AW-1:0]             ptr_q;
    logic [AW-1:0]             ptr_d;

    // Address used by the following accept.
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_q == AW'(C_DEPTH - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    // Write pointer advances once per accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

    // Block RAM: write current slot, registered read of the next slot.
    always_ff @(posedge clk) begin
        if (accept_i) begin
            mem[ptr_q] <= din_i;
            dout_q     <= mem[ptr_d];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/window_generator.sv
// Streaming KxK window generator (valid-only, no padding).
// Optional feature: define WINDOW_COUNT_EN to add the window_count output,
// the number of windows emitted since the last start of frame.
module window_generator
    import window_generator_pkg::*;
#(
    parameter int C_SIGNAL_WIDTH     = DEFAULT_SIGNAL_WIDTH,
    parameter int C_KERNEL_DIMENSION = DEFAULT_KERNEL_DIMENSION,
    parameter int C_IMAGE_WIDTH      = DEFAULT_IMAGE_WIDTH,
    parameter int C_IMAGE_HEIGHT     = DEFAULT_IMAGE_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [C_SIGNAL_WIDTH-1:0] pixel_in,
    input  logic                      pixel_valid,
    input  logic                      sof,
    output logic [0:C_KERNEL_DIMENSION-1][0:C_KERNEL_DIMENSION-1][C_SIGNAL_WIDTH-1:0] window_output,
    output logic                      window_valid,
    output logic                      window_last
`ifdef WINDOW_COUNT_EN
    ,
    output logic [$clog2(C_IMAGE_WIDTH*C_IMAGE_HEIGHT+1)-1:0] window_count
`endif
);

    localparam int K     = C_KERNEL_DIMENSION;
    localparam int SW    = C_SIGNAL_WIDTH;
    localparam int CW    = index_width(C_IMAGE_WIDTH);
    localparam int RW    = index_width(C_IMAGE_HEIGHT);

    logic          accept;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          win_hit;
    logic          last_hit;
    logic          valid_q;
    logic          last_q;
    logic [SW-1:0] lb_dout [K-1];

    assign accept = en & pixel_valid;

    // Position of the pixel being presented and the position expected next.
    always_comb begin
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        col_d    = cur_col + CW'(1);
        row_d    = cur_row;
        if (cur_col == CW'(C_IMAGE_WIDTH - 1)) begin
            col_d = '0;
            if (cur_row == RW'(C_IMAGE_HEIGHT - 1)) begin
                row_d = '0;
            end else begin
                row_d = cur_row + RW'(1);
            end
        end
        win_hit  = accept && (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));
        last_hit = win_hit && (cur_row == RW'(C_IMAGE_HEIGHT - 1))
                           && (cur_col == CW'(C_IMAGE_WIDTH - 1));
    end

    // Raster counters plus one-cycle valid/last strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= win_hit;
            last_q  <= last_hit;
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
            end
        end
    end

    // Chained line buffers: buffer gi delivers the pixel from gi+1 rows above.
    generate
        for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
            logic [SW-1:0] lb_in;
            if (gi == 0) begin : g_head
                assign lb_in = pixel_in;
            end else begin : g_chain
                assign lb_in = lb_dout[gi-1];
            end
            window_generator_line_buffer #(
                .C_SIGNAL_WIDTH (SW),
                .C_DEPTH        (C_IMAGE_WIDTH)
            ) u_line_buffer (
                .clk      (clk),
                .rst      (rst),
                .accept_i (accept),
                .din_i    (lb_in),
                .dout_o   (lb_dout[gi])
            );
        end
    endgenerate

    // Window rows: row K-1 takes the live pixel, row k takes buffer K-2-k.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_row
            logic [SW-1:0]          tap;
            logic [0:K-1][SW-1:0]   row_q;
            if (gi == K - 1) begin : g_live
                assign tap = pixel_in;
            end else begin : g_buf
                assign tap = lb_dout[K-2-gi];
            end
            // Shift the row one column older and append the new tap.
            always_ff @(posedge clk) begin
                if (rst) begin
                    row_q <= '0;
                end else if (accept) begin
                    row_q <= {row_q[1:K-1], tap};
                end
            end
            assign window_output[gi] = row_q;
        end
    endgenerate

    assign window_valid = valid_q;
    assign window_last  = last_q;

`ifdef WINDOW_COUNT_EN
    localparam int NW = $clog2(C_IMAGE_WIDTH*C_IMAGE_HEIGHT+1);
    logic [NW-1:0] count_q;
    logic [NW-1:0] count_d;

    // Restart at a start of frame or after the final window was shown.
    always_comb begin
        count_d = (sof || last_q) ? '0 : count_q;
        count_d = count_d + NW'(win_hit);
    end

    // Window counter follows the valid strobe on accepted pixels only.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_d;
        end
    end

    assign window_count = count_q;
`endif

endmodule
